verdict_evaluator: RTL
======================

Name: verdict_evaluator

Overview:
Downstream of the per-sample physiological detector. It consumes the detector's registered alarm, BP, BR and HB flags over one question window of WINDOW valid samples and produces a per-question lie/truth verdict. The verdict is held until acknowledged by the session controller or display logic. Question windows run back to back under a start/ack handshake.

Parameters:
WINDOW, 16, valid samples per question window (legal range 1..255)
LIE_THRESH, 4, alarm samples in a window at or above which lie=1 (legal range 1..WINDOW)
CNT_W, 8, width of alarm_count (must hold WINDOW)
Q_W, 4, width of question_id
STREAK_THRESH, 3, consecutive-alarm run length that forces lie=1 (used only with the optional feature)

Ports:
clk  input  1  rising-edge clock, the same clock as the detector
rst  input  1  asynchronous, active-high reset
start  input  1  opens a question window; honoured only in IDLE, or in HOLD together with verdict_ack
abort  input  1  cancels the current window; honoured only in SAMPLE
sample_valid  input  1  detector flags on this cycle are a new sample
alarm  input  1  detector alarm flag
BP  input  1  detector blood-pressure flag
BR  input  1  detector breath-rate flag
HB  input  1  detector heartbeat flag
verdict_ack  input  1  consumer accepts the held verdict
busy  output  1  high in SAMPLE and HOLD
verdict_valid  output  1  high throughout HOLD
lie  output  1  verdict; meaningful while verdict_valid=1
alarm_count  output  CNT_W  alarm samples counted in the window
flag_mask  output  3  sticky {BP,BR,HB}: a bit is 1 if that flag was seen on any valid sample in the window
question_id  output  Q_W  index of the current or held question
max_streak  output  CNT_W  longest run of consecutive alarm samples (optional feature)

Behaviour:
- Reset (async, rst=1):
  - State goes to IDLE.
  - busy, verdict_valid, lie, alarm_count, flag_mask, question_id, max_streak and the internal sample counter all go to 0.
  - Reset asserted mid-window or mid-HOLD discards everything; no verdict is emitted.
- FSM states: IDLE, SAMPLE, HOLD.
- IDLE:
  - start=1 moves to SAMPLE on the next edge.
  - On that edge, alarm_count, flag_mask, the sample counter and the streak registers clear.
  - question_id is unchanged.
- SAMPLE, on each edge with sample_valid=1:
  - sample counter +1.
  - alarm_count +alarm.
  - flag_mask |= {BP,BR,HB}.
  - Cycles with sample_valid=0 change nothing.
  - start is ignored in SAMPLE.
- Window close:
  - The edge that accepts the WINDOW-th valid sample also moves to HOLD.
  - On that same edge: lie = ((alarm_count + alarm) >= LIE_THRESH). The final sample counts.
  - verdict_valid rises on that edge. Latency from the last sample to verdict_valid is 1 cycle.
- abort in SAMPLE:
  - Moves to IDLE on the next edge, with no verdict and no question_id increment.
  - Counters keep their values until the next start.
  - abort takes priority over a simultaneous final sample.
- HOLD:
  - lie, alarm_count, flag_mask and max_streak are frozen.
  - sample_valid and abort are ignored.
  - Stays in HOLD indefinitely without verdict_ack.
- verdict_ack in HOLD:
  - question_id increments, wrapping from 2^Q_W-1 to 0.
  - verdict_valid drops on the same edge.
  - Next state is SAMPLE if start=1 that cycle (counters cleared, back-to-back windows with no IDLE cycle); otherwise IDLE.
- verdict_ack outside HOLD is ignored.
- Arithmetic: all counters are unsigned. alarm_count cannot overflow for legal parameters. The implementation also saturates it at 2^CNT_W-1.
- Parameter checks: LIE_THRESH > WINDOW, or WINDOW = 0, is a configuration error flagged by an elaboration-time check.

Optional Feature:
Macro STREAK_DETECT_EN.
- Enabled:
  - A run counter increments on each valid sample with alarm=1 and clears on each valid sample with alarm=0.
  - max_streak tracks the maximum run, including the final sample of the window.
  - lie = (count >= LIE_THRESH) OR (max_streak >= STREAK_THRESH).
- Disabled:
  - No run logic.
  - max_streak is tied to 0.
  - lie depends on alarm_count only.

Test Plan:
1. Reset, start, 16 valid samples with alarm=1 on samples 2, 5, 9 and 14 → verdict_valid 1 cycle after sample 16; lie=1, alarm_count=4; held until ack; then question_id 0→1.
2. Same window with alarm on 3 samples, BR=1 on one of them and HB=1 on another → lie=0, alarm_count=3, flag_mask=3'b011.
3. sample_valid toggling every other cycle over 32 cycles → verdict exactly after the 16th valid sample; invalid cycles do not count.
4. abort after 10 samples, then start and 16 clean samples → only one verdict, lie=0, question_id still 0 before ack.
5. verdict_ack and start in the same HOLD cycle → busy stays 1, verdict_valid drops, next window counts from 0; rst pulsed mid-window → all outputs 0 asynchronously, before the next clock edge.
6. With STREAK_DETECT_EN: 3 consecutive alarms and no others → alarm_count=3, max_streak=3, lie=1. Without the macro, the same stimulus gives lie=0 and max_streak=0.

Source files
------------

// File: rtl/verdict_evaluator_if.sv
// Bundle between the session controller / detector and verdict_evaluator.
// The slave side is the evaluator; the master side drives questions and samples.
interface verdict_evaluator_if #(
  parameter int CNT_W = 8,
  parameter int Q_W   = 4
);
  logic             start;
  logic             abort;
  logic             sample_valid;
  logic             alarm;
  logic             BP;
  logic             BR;
  logic             HB;
  logic             verdict_ack;
  logic             busy;
  logic             verdict_valid;
  logic             lie;
  logic [CNT_W-1:0] alarm_count;
  logic [2:0]       flag_mask;
  logic [Q_W-1:0]   question_id;
  logic [CNT_W-1:0] max_streak;

  modport master (
    output start, abort, sample_valid,
    output alarm, BP, BR, HB, verdict_ack,
    input  busy, verdict_valid, lie,
    input  alarm_count, flag_mask,
    input  question_id, max_streak
  );

  modport slave (
    input  start, abort, sample_valid,
    input  alarm, BP, BR, HB, verdict_ack,
    output busy, verdict_valid, lie,
    output alarm_count, flag_mask,
    output question_id, max_streak
  );
endinterface

// File: rtl/verdict_evaluator.sv
// Per-question lie/truth verdict over a window of detector samples.
// Define STREAK_DETECT_EN to add the consecutive-alarm streak rule.
module verdict_evaluator #(
  parameter int WINDOW        = 16,
  parameter int LIE_THRESH    = 4,
  parameter int CNT_W         = 8,
  parameter int Q_W           = 4,
  parameter int STREAK_THRESH = 3
) (
  input logic               clk,
  input logic               rst,
  verdict_evaluator_if.slave bus
);

  if (WINDOW < 1 || WINDOW > (2**CNT_W) - 1 ||
      LIE_THRESH < 1 || LIE_THRESH > WINDOW ||
      STREAK_THRESH < 1) begin : g_bad_cfg
    $error("verdict_evaluator: illegal parameters");
  end

  typedef enum logic [1:0] {
    IDLE,
    SAMPLE,
    HOLD
  } state_t;

  localparam logic [CNT_W-1:0] CMAX  = '1;
  localparam logic [CNT_W-1:0] WLAST = CNT_W'(WINDOW - 1);
  localparam logic [CNT_W-1:0] LT    = CNT_W'(LIE_THRESH);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] acnt_q, acnt_d;
  logic [2:0]       mask_q, mask_d;
  logic [Q_W-1:0]   qid_q, qid_d;
  logic             lie_q, lie_d;
  logic [CNT_W-1:0] acnt_inc;
  logic             hit_lie;
  logic             clear;

`ifdef STREAK_DETECT_EN
  localparam logic [CNT_W-1:0] ST = CNT_W'(STREAK_THRESH);
  logic [CNT_W-1:0] run_q, run_d;
  logic [CNT_W-1:0] maxs_q, maxs_d;
  logic [CNT_W-1:0] run_inc;
  logic [CNT_W-1:0] maxs_inc;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acnt_d  = acnt_q;
    mask_d  = mask_q;
    qid_d   = qid_q;
    lie_d   = lie_q;
    clear   = 1'b0;
    acnt_inc = (acnt_q == CMAX) ? acnt_q
             : acnt_q + CNT_W'(bus.alarm);
    // The final sample of the window is included in the verdict.
    hit_lie = (acnt_inc >= LT);
`ifdef STREAK_DETECT_EN
    run_d  = run_q;
    maxs_d = maxs_q;
    if (!bus.alarm)
      run_inc = '0;
    else if (run_q == CMAX)
      run_inc = run_q;
    else
      run_inc = run_q + 1'b1;
    maxs_inc = (run_inc > maxs_q) ? run_inc : maxs_q;
    hit_lie = hit_lie || (maxs_inc >= ST);
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = SAMPLE;
          clear   = 1'b1;
        end
      end
      SAMPLE: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else if (bus.sample_valid) begin
          cnt_d  = cnt_q + 1'b1;
          acnt_d = acnt_inc;
          mask_d = mask_q | {bus.BP, bus.BR, bus.HB};
`ifdef STREAK_DETECT_EN
          run_d  = run_inc;
          maxs_d = maxs_inc;
`endif
          if (cnt_q == WLAST) begin
            state_d = HOLD;
            lie_d   = hit_lie;
          end
        end
      end
      HOLD: begin
        if (bus.verdict_ack) begin
          qid_d = qid_q + 1'b1;
          if (bus.start) begin
            state_d = SAMPLE;
            clear   = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (clear) begin
      cnt_d  = '0;
      acnt_d = '0;
      mask_d = '0;
      lie_d  = 1'b0;
`ifdef STREAK_DETECT_EN
      run_d  = '0;
      maxs_d = '0;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acnt_q  <= '0;
      mask_q  <= '0;
      qid_q   <= '0;
      lie_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acnt_q  <= acnt_d;
      mask_q  <= mask_d;
      qid_q   <= qid_d;
      lie_q   <= lie_d;
    end
  end

`ifdef STREAK_DETECT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_q  <= '0;
      maxs_q <= '0;
    end else begin
      run_q  <= run_d;
      maxs_q <= maxs_d;
    end
  end
  assign bus.max_streak = maxs_q;
`else
  assign bus.max_streak = '0;
`endif

  assign bus.busy          = (state_q != IDLE);
  assign bus.verdict_valid = (state_q == HOLD);
  assign bus.lie           = lie_q;
  assign bus.alarm_count   = acnt_q;
  assign bus.flag_mask     = mask_q;
  assign bus.question_id   = qid_q;

endmodule
